register_file_mp: RTL

Parametrised multi-port integer register file for the pipelined core: NREAD combinational read ports and NWRITE clocked write ports (ALU and load writeback). Register 0 is hardwired to zero. An optional same-cycle write-to-read bypass is provided. A per-register busy scoreboard tracks registers with an in-flight producer, so issue logic can detect RAW hazards.

---
 rtl/register_file_mp.sv | 83 ++++++++
 1 files changed

// File: rtl/register_file_mp.sv
// Multi-port integer register file with hardwired-zero x0, optional write-to-read
// bypass and a per-register busy scoreboard for RAW hazard detection at issue.
module register_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREAD*AW-1:0]      rd_addr,
  output logic [NREAD*XLEN-1:0]    rd_data,
  output logic [NREAD-1:0]         rd_busy,
  input  logic [NWRITE-1:0]        wr_en,
  input  logic [NWRITE*AW-1:0]     wr_addr,
  input  logic [NWRITE*XLEN-1:0]   wr_data,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_rd,
  output logic [AW:0]              busy_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + (AW+1)'(v[i]);
    return c;
  endfunction

  // Writebacks release their register first; a same-cycle issue then re-marks it.
  always_comb begin
    busy_next = busy;
    for (int i = 0; i < NWRITE; i++) begin
      if (wr_en[i] && (wr_addr[i*AW +: AW] != '0))
        busy_next[wr_addr[i*AW +: AW]] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0))
      busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Write ports are applied in ascending order so the highest index wins a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      for (int i = 0; i < NWRITE; i++) begin
        if (wr_en[i] && (wr_addr[i*AW +: AW] != '0))
          regs[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
      end
      busy     <= busy_next;
      busy_cnt <= popcount(busy_next);
    end
  end

  // Bypassed data is already valid, so it is never reported as busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (rd_addr[k*AW +: AW] != '0) begin
        rd_data[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
        rd_busy[k]              = busy[rd_addr[k*AW +: AW]];
        if (BYPASS != 0) begin
          for (int i = 0; i < NWRITE; i++) begin
            if (wr_en[i] && (wr_addr[i*AW +: AW] == rd_addr[k*AW +: AW])) begin
              rd_data[k*XLEN +: XLEN] = wr_data[i*XLEN +: XLEN];
              rd_busy[k]              = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule
